// File: rtl/parking_pkg.sv
// Shared constants and types for the parking-lot command path.
// The occupancy FSM decodes commands with these same values.
package parking_pkg;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_ENTER = 2'b10;
  localparam logic [1:0] CMD_EXIT  = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } emit_state_e;

endpackage

// File: rtl/sensor_debounce.sv
// 2-flop synchroniser plus debouncer for one sensor.
// Emits a registered one-cycle rise pulse when the accepted level goes 0->1.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable,
  output logic rise
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            stable_q, stable_d;
  logic            rise_q, rise_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = din;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    cnt_d    = '0;
    // Level is accepted on the sample after the counter has reached the limit.
    if (sync2_q != stable_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES)) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;

endmodule

// File: rtl/parking_sensor_encoder.sv
// Turns debounced entry/exit sensor rises into single-cycle, spaced command words
// for the occupancy FSM, holding at most one pending event per type.
module parking_sensor_encoder
  import parking_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter_raw,
  input  logic       exit_raw,
  input  logic [1:0] exit_place_raw,
  output logic [3:0] cmd,
  output logic       dropped
);

  localparam int unsigned GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GapLast = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  logic enter_stable, exit_stable, enter_rise, exit_rise;
  logic unused_stable;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clk   (clk),
    .reset (reset),
    .din   (enter_raw),
    .stable(enter_stable),
    .rise  (enter_rise)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_db (
    .clk   (clk),
    .reset (reset),
    .din   (exit_raw),
    .stable(exit_stable),
    .rise  (exit_rise)
  );

  assign unused_stable = enter_stable ^ exit_stable;

  logic [1:0]      place_s1_q, place_s2_q;
  logic            pend_enter_q, pend_enter_d;
  logic            pend_exit_q, pend_exit_d;
  logic [1:0]      pend_place_q, pend_place_d;
  logic            dropped_q, dropped_d;
  logic [3:0]      cmd_q, cmd_d;
  logic            rr_exit_q, rr_exit_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  emit_state_e     state_q, state_d;
  logic            try_issue, grant_enter, grant_exit;

  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    rr_exit_d    = rr_exit_q;
    cmd_d        = {CMD_IDLE, 2'b00};
    try_issue    = 1'b0;
    grant_enter  = 1'b0;
    grant_exit   = 1'b0;
    pend_enter_d = pend_enter_q;
    pend_exit_d  = pend_exit_q;
    pend_place_d = pend_place_q;
    dropped_d    = 1'b0;

    unique case (state_q)
      IDLE:  try_issue = 1'b1;
      ISSUE: begin
        if (GAP_CYCLES == 0) begin
          try_issue = 1'b1;
        end else begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end
      end
      GAP: begin
        if (gap_cnt_q == GapW'(GapLast)) try_issue = 1'b1;
        else gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // The last free cycle doubles as the selection cycle, so back-to-back
    // commands are separated by exactly GAP_CYCLES idle words.
    if (try_issue) begin
      state_d = IDLE;
      if (pend_enter_q && (!pend_exit_q || !rr_exit_q)) grant_enter = 1'b1;
      else if (pend_exit_q)                             grant_exit  = 1'b1;
      // Pointer only moves on a contested grant.
      if (pend_enter_q && pend_exit_q) rr_exit_d = grant_enter;
    end

    if (grant_enter) begin
      state_d      = ISSUE;
      cmd_d        = {CMD_ENTER, 2'b00};
      pend_enter_d = 1'b0;
    end
    if (grant_exit) begin
      state_d     = ISSUE;
      cmd_d       = {CMD_EXIT, pend_place_q};
      pend_exit_d = 1'b0;
    end

    if (enter_rise) begin
      if (pend_enter_q && !grant_enter) dropped_d = 1'b1;
      pend_enter_d = 1'b1;
    end
    if (exit_rise) begin
      if (pend_exit_q && !grant_exit) begin
        dropped_d = 1'b1;
      end else begin
        pend_exit_d  = 1'b1;
        pend_place_d = place_s2_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      place_s1_q   <= '0;
      place_s2_q   <= '0;
      pend_enter_q <= 1'b0;
      pend_exit_q  <= 1'b0;
      pend_place_q <= '0;
      dropped_q    <= 1'b0;
      cmd_q        <= '0;
      rr_exit_q    <= 1'b0;
      gap_cnt_q    <= '0;
      state_q      <= IDLE;
    end else begin
      place_s1_q   <= exit_place_raw;
      place_s2_q   <= place_s1_q;
      pend_enter_q <= pend_enter_d;
      pend_exit_q  <= pend_exit_d;
      pend_place_q <= pend_place_d;
      dropped_q    <= dropped_d;
      cmd_q        <= cmd_d;
      rr_exit_q    <= rr_exit_d;
      gap_cnt_q    <= gap_cnt_d;
      state_q      <= state_d;
    end
  end

  assign cmd     = cmd_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_parking_sensor_encoder.sv
// Directed bench for parking_sensor_encoder; a second instance with a long
// gap exercises the pending-slot overflow path.
module tb_parking_sensor_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enter_raw = 1'b0, exit_raw = 1'b0;
  logic [1:0] exit_place_raw = 2'b00;
  logic [3:0] cmd;
  logic       dropped;
  logic       enter2_raw = 1'b0, exit2_raw = 1'b0;
  logic [1:0] place2_raw = 2'b00;
  logic [3:0] cmd2;
  logic       dropped2;

  int unsigned n_checks = 0, n_pass = 0, cyc = 0, n0 = 0;
  int unsigned drop_cnt = 0, bad_code = 0, held_cnt = 0;
  int unsigned enter2_cnt = 0, other2_cnt = 0, drop2_cnt = 0;
  logic [3:0]  prev_cmd = 4'b0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  cmd;
  } ev_t;
  ev_t evq[$];

  parking_sensor_encoder #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(1)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .enter_raw     (enter_raw),
    .exit_raw      (exit_raw),
    .exit_place_raw(exit_place_raw),
    .cmd           (cmd),
    .dropped       (dropped)
  );

  parking_sensor_encoder #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(30)) u_dut_gap (
    .clk           (clk),
    .reset         (reset),
    .enter_raw     (enter2_raw),
    .exit_raw      (exit2_raw),
    .exit_place_raw(place2_raw),
    .cmd           (cmd2),
    .dropped       (dropped2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmd != 4'b0) evq.push_back(ev_t'{cyc, cmd});
    if (cmd[3:2] == 2'b11) bad_code <= bad_code + 1;
    if (cmd != 4'b0 && prev_cmd != 4'b0) held_cnt <= held_cnt + 1;
    prev_cmd <= cmd;
    if (dropped) drop_cnt <= drop_cnt + 1;
    if (cmd2 == 4'b1000) enter2_cnt <= enter2_cnt + 1;
    else if (cmd2 != 4'b0) other2_cnt <= other2_cnt + 1;
    if (dropped2) drop2_cnt <= drop2_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [31:0] ev_cmd(input int i);
    return (evq.size() > i) ? 32'(evq[i].cmd) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ev_lat(input int i);
    return (evq.size() > i) ? evq[i].cyc - n0 : 32'hFFFF_FFFF;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    tick(3);
    check_eq("rst_cmd", cmd, 0);
    check_eq("rst_dropped", dropped, 0);
    check_eq("rst_cmd2", cmd2, 0);
    check_eq("rst_dropped2", dropped2, 0);
    reset = 1'b1;
    tick(2);

    // Clean enter press: one 1000 pulse, 8 edges after the first sampling edge.
    evq.delete();
    n0 = cyc;
    enter_raw = 1'b1;
    tick(20);
    enter_raw = 1'b0;
    tick(20);
    check_eq("t1_count", evq.size(), 1);
    check_eq("t1_cmd", ev_cmd(0), 4'b1000);
    check_eq("t1_latency", ev_lat(0), 9);
    check_eq("t1_dropped", drop_cnt, 0);

    // Bouncing enter never settles.
    evq.delete();
    for (int i = 0; i < 30; i++) begin
      enter_raw = (i % 4) < 2;
      tick(1);
    end
    enter_raw = 1'b0;
    tick(20);
    check_eq("t2_bounce_count", evq.size(), 0);

    // Exit place captured at the event; a later change is ignored.
    evq.delete();
    exit_place_raw = 2'b10;
    n0 = cyc;
    exit_raw = 1'b1;
    tick(8);
    exit_place_raw = 2'b01;
    tick(2);
    exit_raw = 1'b0;
    tick(20);
    check_eq("t3_count", evq.size(), 1);
    check_eq("t3_cmd", ev_cmd(0), 4'b0110);
    check_eq("t3_latency", ev_lat(0), 9);

    // Simultaneous pairs: enter first, then round-robin gives exit first.
    for (int p = 0; p < 2; p++) begin
      evq.delete();
      exit_place_raw = 2'b11;
      n0 = cyc;
      enter_raw = 1'b1;
      exit_raw = 1'b1;
      tick(10);
      enter_raw = 1'b0;
      exit_raw = 1'b0;
      tick(20);
      check_eq($sformatf("t4_p%0d_count", p), evq.size(), 2);
      check_eq($sformatf("t4_p%0d_first", p), ev_cmd(0), (p == 0) ? 4'b1000 : 4'b0111);
      check_eq($sformatf("t4_p%0d_first_lat", p), ev_lat(0), 9);
      check_eq($sformatf("t4_p%0d_second", p), ev_cmd(1), (p == 0) ? 4'b0111 : 4'b1000);
      check_eq($sformatf("t4_p%0d_second_lat", p), ev_lat(1), 11);
    end

    // Long-gap instance: second enter waits, third one finds the slot full.
    for (int i = 0; i < 3; i++) begin
      enter2_raw = 1'b1;
      tick(7);
      enter2_raw = 1'b0;
      tick(7);
    end
    tick(50);
    check_eq("t5_enter_cmds", enter2_cnt, 2);
    check_eq("t5_dropped_pulses", drop2_cnt, 1);
    check_eq("t5_other_cmds", other2_cnt, 0);

    // Reset in GAP with an exit pending: the exit is lost.
    evq.delete();
    exit_place_raw = 2'b01;
    n0 = cyc;
    enter_raw = 1'b1;
    exit_raw = 1'b1;
    tick(10);
    reset = 1'b0;
    enter_raw = 1'b0;
    exit_raw = 1'b0;
    tick(1);
    check_eq("t6_cmd_after_reset", cmd, 0);
    check_eq("t6_dropped_after_reset", dropped, 0);
    tick(1);
    reset = 1'b1;
    tick(25);
    check_eq("t6_count", evq.size(), 1);
    check_eq("t6_cmd", ev_cmd(0), 4'b1000);

    // Sensor held across reset debounces again from zero: one event.
    evq.delete();
    enter_raw = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(20);
    enter_raw = 1'b0;
    tick(20);
    check_eq("t7_count", evq.size(), 1);
    check_eq("t7_cmd", ev_cmd(0), 4'b1000);

    check_eq("never_code_11", bad_code, 0);
    check_eq("never_held_cmd", held_cnt, 0);
    check_eq("main_never_dropped", drop_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
